i2s_rx_unit: RTL and testbench



---
 rtl/audioport_pkg.sv | 10 +
 rtl/i2s_rx_edge_sync.sv | 41 ++++
 rtl/i2s_rx_unit.sv | 179 +++++++++++++++++
 tb/tb_i2s_rx_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/audioport_pkg.sv
// audioport_pkg: shared definitions for the audioport I2S receive path.
//   I2S_RX_DATA_BITS : bits captured per channel slot
//   i2s_rx_state_t   : receiver alignment state (SYNC, LEFT, RIGHT)
package audioport_pkg;

  localparam int I2S_RX_DATA_BITS = 24;

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_edge_sync.sv
// i2s_rx_edge_sync: brings one asynchronous serial input into the clk domain
// through SYNC_STAGES flops and flags its rising edge.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   d_in      : asynchronous input
//   sync_out  : synchronized level
//   rise_out  : 1 for one clk when sync_out goes 0 -> 1
module i2s_rx_edge_sync
  import audioport_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic sync_out,
  output logic rise_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx_unit.sv
// i2s_rx_unit: oversampling I2S receiver (24-bit, stereo, MSB first, standard
// I2S alignment) that rebuilds {left,right} frames and offers them on a
// valid/ready handshake.
// Ports:
//   clk, rst        : system clock (>= 4x sck), synchronous active-high reset
//   sck_in, ws_in,
//   sd_in           : asynchronous I2S bit clock, word select (0=left), data
//   enable_in       : 0 holds the receiver in SYNC
//   audio_out       : {left, right}, valid_out : frame available
//   ready_in        : consumer accepts on valid_out && ready_in
//   overrun_out     : sticky, a completed frame was dropped
//   frame_err_out   : sticky, a short slot was seen
//   clr_in          : clears both sticky flags (a same-cycle set wins)
// Build option: define I2S_RX_FRAME_CHECK_EN to flag short slots and resync;
// without it short slots are accepted left-aligned and frame_err_out stays 0.
module i2s_rx_unit
  import audioport_pkg::*;
#(
  parameter int DATA_BITS   = I2S_RX_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sck_in,
  input  logic                   ws_in,
  input  logic                   sd_in,
  input  logic                   enable_in,
  output logic [2*DATA_BITS-1:0] audio_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   overrun_out,
  output logic                   frame_err_out,
  input  logic                   clr_in
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  logic sck_s, sck_rise, ws_s, sd_s;
  logic ws_rise_unused, sd_rise_unused;

  i2s_rx_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .rst(rst), .d_in(sck_in), .sync_out(sck_s), .rise_out(sck_rise));
  i2s_rx_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ws_sync (
    .clk(clk), .rst(rst), .d_in(ws_in), .sync_out(ws_s), .rise_out(ws_rise_unused));
  i2s_rx_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sd_sync (
    .clk(clk), .rst(rst), .d_in(sd_in), .sync_out(sd_s), .rise_out(sd_rise_unused));

  i2s_rx_state_t          state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   left_q, left_d;
  logic                   ws_prev_q, ws_prev_d;
  logic [2*DATA_BITS-1:0] audio_q, audio_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;

  logic                   ws_chg;
  logic [DATA_BITS-1:0]   shift_inc, slot_word;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   slot_ok, frame_done, err_set, ovr_set;

  assign ws_chg = ws_s ^ ws_prev_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    left_d      = left_q;
    ws_prev_d   = ws_prev_q;
    audio_d     = audio_q;
    valid_d     = valid_q;
    frame_done  = 1'b0;
    err_set     = 1'b0;
    ovr_set     = 1'b0;

    // Slot contents including the bit sampled this sck edge; once the
    // counter saturates, padding bits leave the slot untouched.
    if (bit_cnt_q < CNT_W'(DATA_BITS)) begin
      shift_inc = {shift_q[DATA_BITS-2:0], sd_s};
      cnt_inc   = bit_cnt_q + CNT_W'(1);
    end else begin
      shift_inc = shift_q;
      cnt_inc   = bit_cnt_q;
    end
    // Left-align a short slot, zero-filling the missing LSBs.
    slot_word = shift_inc << (CNT_W'(DATA_BITS) - cnt_inc);

`ifdef I2S_RX_FRAME_CHECK_EN
    slot_ok = (cnt_inc == CNT_W'(DATA_BITS));
`else
    slot_ok = 1'b1;
`endif

    if (sck_rise) ws_prev_d = ws_s;

    if (!enable_in) begin
      state_d   = SYNC;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (sck_rise) begin
      case (state_q)
        SYNC: begin
          // The bit on the falling-ws edge belongs to the previous slot.
          if (ws_chg && !ws_s) begin
            state_d   = LEFT;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        LEFT, RIGHT: begin
          if (ws_chg) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            if (!slot_ok) begin
              err_set = 1'b1;
              state_d = SYNC;
            end else if (state_q == LEFT) begin
              left_d  = slot_word;
              state_d = RIGHT;
            end else begin
              frame_done = 1'b1;
              state_d    = LEFT;
            end
          end else begin
            shift_d   = shift_inc;
            bit_cnt_d = cnt_inc;
          end
        end
        default: state_d = SYNC;
      endcase
    end

    // Output handshake: a completed frame replaces the held one only if
    // the held one is gone or being accepted this cycle.
    if (valid_q && ready_in) valid_d = 1'b0;
    if (frame_done) begin
      if (!valid_q || ready_in) begin
        audio_d = {left_q, slot_word};
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    overrun_d   = (overrun_q & ~clr_in) | ovr_set;
    frame_err_d = (frame_err_q & ~clr_in) | err_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_q      <= '0;
      ws_prev_q   <= 1'b0;
      audio_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      ws_prev_q   <= ws_prev_d;
      audio_q     <= audio_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign audio_out     = audio_q;
  assign valid_out     = valid_q;
  assign overrun_out   = overrun_q;
  assign frame_err_out = frame_err_q;

endmodule

// File: tb/tb_i2s_rx_unit.sv
// tb_i2s_rx_unit: drives I2S streams into i2s_rx_unit and checks received
// frames against a queue of expected {left,right} words, plus sticky flags,
// reset/enable resynchronization and backpressure.
// Honours I2S_RX_FRAME_CHECK_EN in the short-slot case.
`timescale 1ns/1ps
module tb_i2s_rx_unit;
  import audioport_pkg::*;

  localparam int DB = I2S_RX_DATA_BITS;

  logic          clk = 1'b0;
  logic          rst, sck_in, ws_in, sd_in, enable_in, ready_in, clr_in;
  logic [2*DB-1:0] audio_out;
  logic          valid_out, overrun_out, frame_err_out;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            rx_cnt  = 0;
  logic [2*DB-1:0] exp_q[$];
  logic          held_sd;

  always #5 clk = ~clk;

  i2s_rx_unit dut (
    .clk(clk), .rst(rst), .sck_in(sck_in), .ws_in(ws_in), .sd_in(sd_in),
    .enable_in(enable_in), .audio_out(audio_out), .valid_out(valid_out),
    .ready_in(ready_in), .overrun_out(overrun_out),
    .frame_err_out(frame_err_out), .clr_in(clr_in));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One sck period (4 clk). ws leads data by one bit: the wire carries the
  // ws of the slot the *next* bit belongs to, with the previously queued bit.
  task automatic push_bit(input logic w, input logic b);
    sck_in = 1'b0;
    ws_in  = w;
    sd_in  = held_sd;
    wait_clk(2);
    sck_in = 1'b1;
    wait_clk(2);
    held_sd = b;
  endtask

  task automatic send_slot(input logic w, input logic [DB-1:0] word,
                           input int nbits, input int total);
    for (int i = 0; i < total; i++)
      push_bit(w, (i < nbits) ? word[DB-1-i] : 1'b0);
  endtask

  task automatic send_frame(input logic [DB-1:0] l, input logic [DB-1:0] r,
                            input int nl, input int tot_l, input int tot_r);
    send_slot(1'b0, l, nl, tot_l);
    send_slot(1'b1, r, DB, tot_r);
  endtask

  // Clock out the last right LSB and let the frame land.
  task automatic flush();
    push_bit(1'b0, 1'b0);
    push_bit(1'b0, 1'b0);
    wait_clk(12);
  endtask

  // Park the receiver in SYNC, then start a fresh right slot so the next
  // frame begins on a falling ws.
  task automatic resync();
    enable_in = 1'b0;
    wait_clk(4);
    enable_in = 1'b1;
    send_slot(1'b1, 24'h0, DB, DB);
  endtask

  // Scoreboard: each accepted frame must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) begin
      rx_cnt++;
      chk("frame_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("audio_out", 64'(audio_out), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    int base;
    logic [DB-1:0] short_l;
    rst = 1'b1; sck_in = 1'b0; ws_in = 1'b0; sd_in = 1'b0; held_sd = 1'b0;
    enable_in = 1'b1; ready_in = 1'b1; clr_in = 1'b0;
    wait_clk(4);
    chk("rst_audio",     64'(audio_out),     64'd0);
    chk("rst_valid",     64'(valid_out),     64'd0);
    chk("rst_overrun",   64'(overrun_out),   64'd0);
    chk("rst_frame_err", 64'(frame_err_out), 64'd0);
    rst = 1'b0;
    wait_clk(2);

    // Entered mid-right slot, then one aligned frame.
    send_slot(1'b1, 24'hFFFFFF, 10, 10);
    exp_q.push_back(48'h123456ABCDEF);
    send_frame(24'h123456, 24'hABCDEF, DB, DB, DB);
    flush();
    chk("aligned_count", 64'(rx_cnt), 64'd1);
    chk("aligned_valid_low", 64'(valid_out), 64'd0);
    chk("aligned_overrun", 64'(overrun_out), 64'd0);
    chk("aligned_frame_err", 64'(frame_err_out), 64'd0);
    resync();

    // Backpressure: second frame is lost.
    ready_in = 1'b0;
    exp_q.push_back(48'h000001000002);
    send_frame(24'h000001, 24'h000002, DB, DB, DB);
    send_frame(24'h000003, 24'h000004, DB, DB, DB);
    flush();
    chk("bp_valid",   64'(valid_out),   64'd1);
    chk("bp_hold",    64'(audio_out),   64'h000001000002);
    chk("bp_overrun", 64'(overrun_out), 64'd1);
    clr_in = 1'b1;
    wait_clk(1);
    clr_in = 1'b0;
    wait_clk(1);
    chk("bp_overrun_clr", 64'(overrun_out), 64'd0);
    ready_in = 1'b1;
    wait_clk(3);
    chk("bp_valid_drop", 64'(valid_out), 64'd0);
    chk("bp_count", 64'(rx_cnt), 64'd2);
    resync();

    // Long slots: 32 sck per slot, padding ignored.
    exp_q.push_back(48'h8000007FFFFF);
    send_frame(24'h800000, 24'h7FFFFF, DB, 32, 32);
    flush();
    chk("long_frame_err", 64'(frame_err_out), 64'd0);
    chk("long_count", 64'(rx_cnt), 64'd3);
    resync();

    // Short left slot (20 bits), then a good frame.
    base = rx_cnt;
    short_l = 24'hFEDCBA;
`ifdef I2S_RX_FRAME_CHECK_EN
    send_frame(short_l, 24'h13579B, 20, 20, DB);
`else
    exp_q.push_back({24'hFEDCB0, 24'h13579B});
    send_frame(short_l, 24'h13579B, 20, 20, DB);
`endif
    exp_q.push_back(48'h2468ACBDF135);
    send_frame(24'h2468AC, 24'hBDF135, DB, DB, DB);
    flush();
`ifdef I2S_RX_FRAME_CHECK_EN
    chk("short_frame_err", 64'(frame_err_out), 64'd1);
    chk("short_count", 64'(rx_cnt - base), 64'd1);
`else
    chk("short_frame_err", 64'(frame_err_out), 64'd0);
    chk("short_count", 64'(rx_cnt - base), 64'd2);
`endif
    clr_in = 1'b1;
    wait_clk(1);
    clr_in = 1'b0;
    wait_clk(1);
    chk("short_err_clr", 64'(frame_err_out), 64'd0);
    resync();

    // rst after 10 left bits.
    base = rx_cnt;
    send_slot(1'b0, 24'hAAAAAA, 10, 10);
    sck_in = 1'b0;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    chk("midrst_audio",   64'(audio_out),   64'd0);
    chk("midrst_valid",   64'(valid_out),   64'd0);
    chk("midrst_overrun", 64'(overrun_out), 64'd0);
    send_slot(1'b0, 24'h0, 14, 14);
    send_slot(1'b1, 24'h555555, DB, DB);
    exp_q.push_back(48'h0F0F0FF0F0F0);
    send_frame(24'h0F0F0F, 24'hF0F0F0, DB, DB, DB);
    flush();
    chk("midrst_count", 64'(rx_cnt - base), 64'd1);
    resync();

    // enable_in low mid-frame while a frame is pending.
    base = rx_cnt;
    ready_in = 1'b0;
    exp_q.push_back(48'h111111222222);
    send_frame(24'h111111, 24'h222222, DB, DB, DB);
    send_slot(1'b0, 24'hAAAAAA, 10, 10);
    sck_in = 1'b0;
    wait_clk(2);
    enable_in = 1'b0;
    wait_clk(4);
    enable_in = 1'b1;
    wait_clk(1);
    chk("en_pending_valid", 64'(valid_out), 64'd1);
    chk("en_pending_audio", 64'(audio_out), 64'h111111222222);
    ready_in = 1'b1;
    wait_clk(3);
    send_slot(1'b0, 24'h0, 14, 14);
    send_slot(1'b1, 24'h555555, DB, DB);
    exp_q.push_back(48'h0C0C0C303030);
    send_frame(24'h0C0C0C, 24'h303030, DB, DB, DB);
    flush();
    chk("en_count", 64'(rx_cnt - base), 64'd2);
    chk("en_overrun", 64'(overrun_out), 64'd0);

    for (int i = 0; i < 500 && exp_q.size() != 0; i++) wait_clk(1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
